// File: rtl/data_transfer_pkg.sv
// data_transfer_pkg
// Shared constants and FSM state types for the data_transfer AXI4-Lite
// register interface (S00_AXI).
package data_transfer_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;  // reserved, never issued

  // Byte offset bits below the register index
  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW_HELD,
    W_W_HELD,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/data_transfer_axil_wr_ctrl.sv
// data_transfer_axil_wr_ctrl
// AXI4-Lite write-channel controller. Accepts AW and W independently,
// holds whichever arrives first, and issues a single-cycle register write
// request on the edge where both have been captured. Response is held
// until bready.
//
// state      | meaning
// -----------+---------------------------------------------------
// W_IDLE     | waiting for AW and/or W; awready=1, wready=1
// W_AW_HELD  | address captured, waiting for data; wready=1
// W_W_HELD   | data/strobe captured, waiting for address; awready=1
// W_RESP     | write done, bvalid=1 until bready
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bvalid/bready           write response channel (bresp is OKAY in top)
//   wr_en/wr_idx/wr_data/wr_strb  register write request to register file
module data_transfer_axil_wr_ctrl
  import data_transfer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          bvalid,
  input  logic                          bready,
  output logic                          wr_en,
  output logic [$clog2(NUM_REGS)-1:0]   wr_idx,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [DATA_WIDTH/8-1:0]       wr_strb
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  w_state_t state, state_nxt;

  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_hs, w_hs, load_aw, load_w;
  logic [IDX_W-1:0]  aw_idx;

  // Upper address bits alias; only the index field is decoded
  logic unused_awaddr;
  assign unused_awaddr = ^awaddr;

  assign aw_idx = awaddr[ADDR_LSB +: IDX_W];
  assign aw_hs  = awvalid & aw_ready_q;
  assign w_hs   = wvalid & w_ready_q;

  assign awready = aw_ready_q;
  assign wready  = w_ready_q;
  assign bvalid  = b_valid_q;

  always_comb begin
    state_nxt = state;
    load_aw   = 1'b0;
    load_w    = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = aw_idx_q;
    wr_data   = w_data_q;
    wr_strb   = w_strb_q;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          state_nxt = W_RESP;
          wr_en     = 1'b1;
          wr_idx    = aw_idx;
          wr_data   = wdata;
          wr_strb   = wstrb;
        end else if (aw_hs) begin
          state_nxt = W_AW_HELD;
          load_aw   = 1'b1;
        end else if (w_hs) begin
          state_nxt = W_W_HELD;
          load_w    = 1'b1;
        end
      end
      W_AW_HELD: begin
        if (w_hs) begin
          state_nxt = W_RESP;
          wr_en     = 1'b1;
          wr_data   = wdata;
          wr_strb   = wstrb;
        end
      end
      W_W_HELD: begin
        if (aw_hs) begin
          state_nxt = W_RESP;
          wr_en     = 1'b1;
          wr_idx    = aw_idx;
        end
      end
      W_RESP: begin
        if (bready) state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // Readies and bvalid are registered from the next state so they change
  // exactly one edge after the transition that causes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      state      <= state_nxt;
      aw_ready_q <= (state_nxt == W_IDLE) || (state_nxt == W_W_HELD);
      w_ready_q  <= (state_nxt == W_IDLE) || (state_nxt == W_AW_HELD);
      b_valid_q  <= (state_nxt == W_RESP);
      if (load_aw) aw_idx_q <= aw_idx;
      if (load_w) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/data_transfer_axil_slave.sv
// data_transfer_axil_slave
// AXI4-Lite slave register file (S00_AXI of the data_transfer IP).
// NUM_REGS x 32-bit read/write registers with byte-strobe writes, exported
// to user logic with a one-cycle write pulse per register.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   s00_axi_aw*, s00_axi_w*, s00_axi_b*   write channels (via wr_ctrl)
//   s00_axi_ar*, s00_axi_r*               read channels (inline FSM)
//   reg_out       register i at [i*32 +: 32]
//   reg_wr_pulse  bit i pulses for one cycle after register i is written
module data_transfer_axil_slave
  import data_transfer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  logic unused_in;
  assign unused_in = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_araddr};

  data_transfer_axil_wr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_ctrl (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .awaddr  (s00_axi_awaddr),
    .awvalid (s00_axi_awvalid),
    .awready (s00_axi_awready),
    .wdata   (s00_axi_wdata),
    .wstrb   (s00_axi_wstrb),
    .wvalid  (s00_axi_wvalid),
    .wready  (s00_axi_wready),
    .bvalid  (s00_axi_bvalid),
    .bready  (s00_axi_bready),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  assign s00_axi_bresp = AXI_RESP_OKAY;
  assign s00_axi_rresp = AXI_RESP_OKAY;

  // Register file with byte-strobe merge; wstrb=0 still pulses
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_en) begin
        reg_wr_pulse[wr_idx] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Read path: rdata is sampled on the AR handshake edge, so a write landing
  // on the same edge is not visible to this read.
  r_state_t              r_state, r_state_nxt;
  logic                  ar_ready_q, r_valid_q, ar_hs;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [IDX_W-1:0]      ar_idx;

  assign ar_idx = s00_axi_araddr[ADDR_LSB +: IDX_W];
  assign ar_hs  = s00_axi_arvalid & ar_ready_q;

  assign s00_axi_arready = ar_ready_q;
  assign s00_axi_rvalid  = r_valid_q;
  assign s00_axi_rdata   = r_data_q;

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (s00_axi_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      r_state    <= r_state_nxt;
      ar_ready_q <= (r_state_nxt == R_IDLE);
      r_valid_q  <= (r_state_nxt == R_DATA);
      if (ar_hs) r_data_q <= regs[ar_idx];
    end
  end

endmodule

// File: doc/data_transfer_axil_slave.md
Name: data_transfer_axil_slave

Overview:
- AXI4-Lite slave register file forming the S00_AXI register interface of the data_transfer IP.
- It is the responder for the AXI VIP master used in the block-design bench.
- It provides NUM_REGS 32-bit read/write registers, with byte-strobe writes and independent write-address and write-data acceptance.
- Register contents are exported to user logic, along with per-register one-cycle write pulses.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 4, AXI address width; must be ≥ ADDR_LSB + log2(NUM_REGS).
- NUM_REGS, 4, number of registers; must be a power of 2, ≥ 2.

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid  in  1
- s00_axi_awready  out  1
- s00_axi_wdata  in  DATA_WIDTH
- s00_axi_wstrb  in  DATA_WIDTH/8
- s00_axi_wvalid  in  1
- s00_axi_wready  out  1
- s00_axi_bresp  out  2  always OKAY (2'b00)
- s00_axi_bvalid  out  1
- s00_axi_bready  in  1
- s00_axi_araddr  in  ADDR_WIDTH
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid  in  1
- s00_axi_arready  out  1
- s00_axi_rdata  out  DATA_WIDTH
- s00_axi_rresp  out  2  always OKAY
- s00_axi_rvalid  out  1
- s00_axi_rready  in  1
- reg_out  out  NUM_REGS*DATA_WIDTH  register i is at slice [i*32 +: 32]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written

Behaviour:
- One clock: s00_axi_aclk. Reset is asynchronous and active-low (s00_axi_aresetn).
- Reset values: all outputs 0, all registers 0.
- Ready outputs are registered. awready, wready and arready rise on the first edge after aresetn is released.
- Register index = addr[ADDR_LSB +: log2(NUM_REGS)], where ADDR_LSB = 2.
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so those addresses alias.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_AW_HELD: AW captured; awready=0, wready=1.
  - W_W_HELD: W captured; awready=1, wready=0.
  - W_RESP: bvalid=1, awready=0, wready=0.
- Write transitions:
  - AW and W handshake in the same cycle → go directly to W_RESP.
  - Only one channel handshakes → hold that channel's payload and wait in the matching *_HELD state.
  - The register update happens on the edge on which both channels have been captured. bvalid and reg_wr_pulse[idx] assert in the following cycle.
  - Latency: AW+W handshake at cycle N → bvalid and updated reg_out at N+1.
- Strobe merge: byte k is updated only when wstrb[k]=1. wstrb=0 still completes with OKAY and still pulses reg_wr_pulse, but changes no data.
- bvalid holds until bready. The edge with bvalid&bready returns the FSM to W_IDLE, and readies rise in the next cycle. No new AW/W is accepted while a response is pending.
- Read FSM states:
  - R_IDLE: arready=1.
  - R_DATA: arready=0, rvalid=1.
- Read timing: rdata is latched on the AR handshake edge, so the read has 1-cycle latency. rdata and rvalid stay stable until rready. rvalid&rready returns the FSM to R_IDLE.
- Simultaneous read and write to the same register in the same cycle: the read returns the pre-write value.
- The read and write paths are fully independent; a stalled B does not block reads and vice versa.
- Reset asserted mid-transaction: immediately clears the FSMs, registers, bvalid and rvalid. No response is issued for the aborted transaction.
- X on valid inputs during reset must not propagate to outputs.

Decomposition:
- Package data_transfer_pkg holds:
  - constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10 (reserved);
  - ADDR_LSB=2;
  - enum typedefs for the write FSM (W_IDLE, W_AW_HELD, W_W_HELD, W_RESP) and read FSM (R_IDLE, R_DATA).
- One natural sub-module: data_transfer_axil_wr_ctrl, containing the write FSM and AW/W holding registers. It outputs wr_en, wr_idx, wr_data and wr_strb to the register file in the top.
- The read path stays inline.

Test Plan:
- Writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with full strobes, then reads of the same addresses → rdata 0x1..0x4, all responses OKAY, reg_out = 0x00000004_00000003_00000002_00000001.
- AW at cycle N with W held off until N+3 (and the reverse order) → awready drops after the AW handshake, bvalid at N+4, reg 0x8 = 0xDEADBEEF, and exactly one reg_wr_pulse[2].
- Reg0 = 0xAABBCCDD, then write 0x11223344 with wstrb=4'b0101 → reg0 reads 0xAA22CC44. Write with wstrb=0 → value unchanged and pulse still seen.
- bready held low for 5 cycles after a write → bvalid stays 1, awready/wready stay 0, and a read issued meanwhile completes with correct data.
- Write 0x55 to 0x4 in the same cycle as AR on 0x4 (old value 0x2) → rdata 0x2; a subsequent read returns 0x55.
- Assert aresetn low while bvalid=1 and rvalid=1 → both drop immediately and all registers read 0 after reset. Address 0x13 aliases to reg0 at ADDR_WIDTH=5.
